interrupt_ack_sequencer: RTL

- Clocked, parametrised successor to the combinational interrupt control signal logic of the 8259A core.
- Owns the INT output and the INTA/poll acknowledge sequence: 2-pulse 8086 mode, 3-pulse 8080 mode with CALL opcode.
- Snapshots the winning request, produces IRR-clear, ISR-set and auto-EOI pulses, and drives the vector/poll byte onto the internal data bus.
- Sits between the priority resolver, the ICW/OCW registers and the data bus buffer.

---
 rtl/interrupt_ack_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: owns INT and the INTA/poll sequence,
// snapshots the winning request and drives vector/poll bytes.
module interrupt_ack_sequencer #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               icw1_write,
  input  logic               mode_8086,
  input  logic               auto_eoi,
  input  logic [NUM_IRQ-1:0] irq_select,
  input  logic               ack_pulse,
  input  logic               poll_read,
  input  logic [7:0]         vector_base,
  input  logic [7:0]         addr_high,
  output logic               int_out,
  output logic               freeze,
  output logic [NUM_IRQ-1:0] clear_request,
  output logic [NUM_IRQ-1:0] in_service_set,
  output logic [NUM_IRQ-1:0] isr_clear_aeoi,
  output logic [7:0]         data_out,
  output logic               data_valid,
  output logic               end_of_sequence
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK1 = 2'd1;
  localparam logic [1:0] ACK2 = 2'd2;

  localparam logic [7:0] IDX_MASK = 8'((1 << IDX_W) - 1);
  localparam logic [7:0] CALL_OP  = 8'hCD;

  logic [1:0]         state;
  logic [NUM_IRQ-1:0] latched;
  logic               spurious;

  logic               irq_any;
  logic               accept;
  logic               ack_spur;
  logic [IDX_W-1:0]   snap_idx;
  logic [7:0]         vec_byte;
  logic [7:0]         poll_byte;
  logic [NUM_IRQ-1:0] aeoi_val;

  function automatic logic [IDX_W-1:0] enc(
    input logic [NUM_IRQ-1:0] v
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (v[i]) r = r | IDX_W'(i);
    return r;
  endfunction

  assign irq_any  = |irq_select;
  assign accept   = !icw1_write && (state == IDLE)
                  && (ack_pulse || poll_read);
  assign freeze   = (state != IDLE) || accept;
  assign ack_spur = !irq_any || !int_out;
  assign snap_idx = spurious ? IDX_W'(NUM_IRQ - 1)
                             : enc(latched);
  assign vec_byte = (vector_base & ~IDX_MASK)
                  | {{(8-IDX_W){1'b0}}, snap_idx};
  assign poll_byte = {irq_any, {(7-IDX_W){1'b0}},
                      enc(irq_select)};
  assign aeoi_val = (auto_eoi && !spurious) ? latched : '0;

  // Sequence FSM, INT flag and all registered pulse/data outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      latched         <= '0;
      spurious        <= 1'b0;
      int_out         <= 1'b0;
      clear_request   <= '0;
      in_service_set  <= '0;
      isr_clear_aeoi  <= '0;
      data_out        <= 8'h00;
      data_valid      <= 1'b0;
      end_of_sequence <= 1'b0;
    end else begin
      clear_request   <= '0;
      in_service_set  <= '0;
      isr_clear_aeoi  <= '0;
      data_valid      <= 1'b0;
      end_of_sequence <= 1'b0;
      if (icw1_write) begin
        state         <= IDLE;
        int_out       <= 1'b0;
        clear_request <= '1;
        latched       <= '0;
        spurious      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (irq_any) int_out <= 1'b1;
            if (ack_pulse) begin
              state    <= ACK1;
              spurious <= ack_spur;
              latched  <= ack_spur ? '0 : irq_select;
              if (!ack_spur) begin
                in_service_set <= irq_select;
                clear_request  <= irq_select;
              end
              if (!mode_8086) begin
                data_out   <= CALL_OP;
                data_valid <= 1'b1;
              end
            end else if (poll_read) begin
              data_out        <= poll_byte;
              data_valid      <= 1'b1;
              end_of_sequence <= 1'b1;
              int_out         <= 1'b0;
              in_service_set  <= irq_select;
              clear_request   <= irq_select;
            end
          end
          ACK1: begin
            if (ack_pulse) begin
              data_out   <= vec_byte;
              data_valid <= 1'b1;
              if (mode_8086) begin
                state           <= IDLE;
                end_of_sequence <= 1'b1;
                isr_clear_aeoi  <= aeoi_val;
                int_out         <= 1'b0;
              end else begin
                state <= ACK2;
              end
            end
          end
          ACK2: begin
            if (ack_pulse) begin
              state           <= IDLE;
              data_out        <= addr_high;
              data_valid      <= 1'b1;
              end_of_sequence <= 1'b1;
              isr_clear_aeoi  <= aeoi_val;
              int_out         <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
